// File: rtl/mem_pkg.sv
// mem_pkg: geometry and control-level constants shared by the SRAM and ROM models.
package mem_pkg;
   localparam int MEM_ADDR_W = 15;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_BYTE_W = 8;
   localparam int MEM_BANKS  = MEM_DATA_W / MEM_BYTE_W;
   localparam int MEM_DEPTH  = 2 ** MEM_ADDR_W;
   localparam int ROM_ADDR_W = 13;
   localparam int ROM_DATA_W = 32;
   localparam logic ACTIVE   = 1'b0;
   localparam logic INACTIVE = 1'b1;
   typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
   typedef logic [MEM_DATA_W-1:0] mem_word_t;
   typedef logic [MEM_BYTE_W-1:0] mem_byte_t;
endpackage

// File: rtl/mod_mem128k_if.sv
// mod_mem128k_if: SRAM address and active-low control strobes.
interface mod_mem128k_if;
   import mem_pkg::*;
   mem_addr_t ADDRESS;
   logic CE_N;
   logic OE_N;
   logic WE_N;
   modport master (output ADDRESS, CE_N, OE_N, WE_N);
   modport slave  (input  ADDRESS, CE_N, OE_N, WE_N);
endinterface

// File: rtl/mod_mem_bank.sv
// mod_mem_bank: one 8-bit byte lane of the SRAM, cleared asynchronously by RST.
module mod_mem_bank
   import mem_pkg::*;
(
   input  logic      CLK,
   input  logic      RST,
   input  mem_addr_t address,
   input  mem_byte_t din,
   input  logic      we,
   output mem_byte_t dout
);
   mem_byte_t buffer [MEM_DEPTH];
   always_ff @(posedge CLK or posedge RST)
      if (RST) buffer <= '{default: '0};
      else if (we) buffer[address] <= din;
   assign dout = buffer[address];
endmodule

// File: rtl/mod_mem128k.sv
// mod_mem128k: 32K x 32 SRAM model; control decode and IO tri-state over four byte banks.
module mod_mem128k
   import mem_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   mod_mem128k_if.slave          bus,
   inout  wire  [MEM_DATA_W-1:0] IO
);
   logic      we;
   logic      drive;
   mem_word_t rdata;
   // WE_N outranks OE_N, so a write never turns the driver on
   assign we    = !RST && bus.CE_N == ACTIVE && bus.WE_N == ACTIVE;
   assign drive = !RST && bus.CE_N == ACTIVE && bus.WE_N == INACTIVE && bus.OE_N == ACTIVE;
   assign IO    = drive ? rdata : 'z;
   mod_mem_bank bank_1 (.CLK(CLK), .RST(RST), .address(bus.ADDRESS), .din(IO[31:24]), .we(we), .dout(rdata[31:24]));
   mod_mem_bank bank_2 (.CLK(CLK), .RST(RST), .address(bus.ADDRESS), .din(IO[23:16]), .we(we), .dout(rdata[23:16]));
   mod_mem_bank bank_3 (.CLK(CLK), .RST(RST), .address(bus.ADDRESS), .din(IO[15:8]),  .we(we), .dout(rdata[15:8]));
   mod_mem_bank bank_4 (.CLK(CLK), .RST(RST), .address(bus.ADDRESS), .din(IO[7:0]),   .we(we), .dout(rdata[7:0]));
endmodule

// File: tb/tb_mod_mem128k.sv
// tb_mod_mem128k: directed stimulus against a sparse word-level memory model.
module tb_mod_mem128k;
   import mem_pkg::*;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic [31:0] tb_d = '0;
   logic tb_en = 1'b0;
   wire  [31:0] IO;
   int checks = 0;
   int failures = 0;
   logic [31:0] model [int];

   mod_mem128k_if bus ();
   mod_mem128k dut (.CLK(CLK), .RST(RST), .bus(bus), .IO(IO));
   assign IO = tb_en ? tb_d : 'z;

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mget(input int a);
      return model.exists(a) ? model[a] : 32'h0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Model: contents vanish on reset; an enabled write edge stores what the bench drove.
   always @(posedge RST) model.delete();
   always @(posedge CLK)
      if (!RST && bus.CE_N == 1'b0 && bus.WE_N == 1'b0) model[int'(bus.ADDRESS)] = tb_d;

   always @(negedge CLK) begin
      logic exp_drive;
      exp_drive = !RST && bus.CE_N == 1'b0 && bus.WE_N == 1'b1 && bus.OE_N == 1'b0;
      chk("cycle_drive", {31'b0, dut.drive}, {31'b0, exp_drive});
      if (exp_drive) chk("cycle_read", IO, mget(int'(bus.ADDRESS)));
   end

   task automatic wr(input int a, input logic [31:0] d);
      @(negedge CLK);
      #1 bus.ADDRESS = mem_addr_t'(a); tb_d = d; tb_en = 1'b1;
      bus.OE_N = 1'b1; bus.CE_N = 1'b0; bus.WE_N = 1'b0;
      @(negedge CLK);
      #1 bus.CE_N = 1'b1; bus.WE_N = 1'b1; tb_en = 1'b0;
   endtask

   task automatic rd(input string name, input int a, input logic [31:0] exp);
      @(negedge CLK);
      #1 bus.ADDRESS = mem_addr_t'(a); bus.CE_N = 1'b0; bus.WE_N = 1'b1; bus.OE_N = 1'b0;
      #1 chk(name, IO, exp);
      chk({name, "_drive"}, {31'b0, dut.drive}, 32'd1);
   endtask

   initial begin
      bus.ADDRESS = '0; bus.CE_N = 1'b0; bus.OE_N = 1'b0; bus.WE_N = 1'b1;
      #2 chk("reset_hiz", {31'b0, dut.drive}, 32'd0);
      repeat (2) @(negedge CLK);
      #1 RST = 1'b0;
      rd("reset_init_0", 0, 32'h0);
      // single write and byte-lane placement
      wr(5, 32'hDEADBEEF);
      rd("wr_readback", 5, 32'hDEADBEEF);
      chk("bank_1_5", {24'b0, dut.bank_1.buffer[5]}, 32'hDE);
      chk("bank_2_5", {24'b0, dut.bank_2.buffer[5]}, 32'hAD);
      chk("bank_3_5", {24'b0, dut.bank_3.buffer[5]}, 32'hBE);
      chk("bank_4_5", {24'b0, dut.bank_4.buffer[5]}, 32'hEF);
      // address change with no clock edge
      wr(6, 32'h0BADF00D);
      rd("async_5", 5, 32'hDEADBEEF);
      #1 bus.ADDRESS = 15'd6;
      #1 chk("async_6", IO, 32'h0BADF00D);
      // write with OE_N also low: block must stay off the bus
      @(negedge CLK);
      #1 bus.ADDRESS = 15'd7; tb_d = 32'h12345678; tb_en = 1'b1;
      bus.CE_N = 1'b0; bus.WE_N = 1'b0; bus.OE_N = 1'b0;
      #1 chk("contention_drive", {31'b0, dut.drive}, 32'd0);
      @(negedge CLK);
      #1 bus.WE_N = 1'b1; tb_en = 1'b0; bus.CE_N = 1'b1;
      rd("contention_store", 7, 32'h12345678);
      for (int k = 0; k < 4; k++) begin
         #1 bus.CE_N = 1'b1; bus.OE_N = k[0]; bus.WE_N = k[1];
         #1 chk($sformatf("ce_off_%0d", k), {31'b0, dut.drive}, 32'd0);
      end
      // sequential fill
      for (int a = 0; a < 128; a++) wr(a, a * 32'h01010101);
      for (int a = 0; a < 128; a++) rd($sformatf("fill_%0d", a), a, a * 32'h01010101);
      rd("fill_128", 128, 32'h0);
      // reset pulse clears everything, including far addresses
      wr(1234, 32'hCAFE1234);
      wr(32767, 32'hFFFF7FFF);
      rd("last_word", 32767, 32'hFFFF7FFF);
      #1 RST = 1'b1;
      #1 chk("rst_hiz", {31'b0, dut.drive}, 32'd0);
      @(negedge CLK);
      #1 RST = 1'b0;
      rd("rst_0", 0, 32'h0);
      rd("rst_1234", 1234, 32'h0);
      rd("rst_32767", 32767, 32'h0);
      // reset between write setup and its edge aborts the write
      wr(9, 32'h99999999);
      rd("pre_abort_9", 9, 32'h99999999);
      @(negedge CLK);
      #1 bus.ADDRESS = 15'd9; tb_d = 32'h5A5A5A5A; tb_en = 1'b1;
      bus.OE_N = 1'b1; bus.CE_N = 1'b0; bus.WE_N = 1'b0;
      #1 RST = 1'b1;
      @(negedge CLK);
      #1 bus.CE_N = 1'b1; bus.WE_N = 1'b1; tb_en = 1'b0;
      #1 RST = 1'b0;
      rd("abort_9", 9, 32'h0);
      @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
